spi_tx: RTL
===========

# spi_tx

SPI master transmitter for the front-panel link: takes bytes from the host logic over a valid/ready handshake and serialises them MSB-first onto SCLK/MOSI/SS, all generated from the system clock. It drives the front-panel ASIC's SPI receiver, which shifts MOSI in on SCLK rising edges while SS is low. The block is mode-0 only: SCLK idles low and MOSI changes only while SCLK is low. It has a one-byte holding register so the host can queue the next byte while the current one shifts.

## Interface
- DIV, 4: CLK cycles per SCLK half-period; legal range 1..255.
- CLK  input  1  system clock; all logic on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- TXDATA  input  8  byte to send.
- TXVALID  input  1  TXDATA is valid.
- TXREADY  output  1  holding register empty; byte accepted on an edge where TXVALID & TXREADY.
- SCLK  output  1  SPI clock, idle low.
- MOSI  output  1  serial data, MSB first.
- SS  output  1  slave select, active low.
- BUSY  output  1  high in any state other than IDLE.
- TXDONE  output  1  one-CLK pulse per byte fully clocked out.

## Operation
- Datapath: 8-bit holding register with a full flag (TXREADY = ~full), an 8-bit shift register, a 3-bit bit counter, and an 8-bit phase counter that counts DIV cycles.
- FSM states:
  - IDLE: SS=1, SCLK=0. If the holding register is full, load the shift register from it, clear full, set SS=0 and MOSI=bit7, then go to SETUP.
  - SETUP: SS=0, SCLK=0 for DIV cycles, then go to HIGH.
  - HIGH: SCLK=1 for DIV cycles. At the end:
    - bit counter < 7: increment it, drive the next bit on MOSI, go to LOW.
    - bit counter = 7: pulse TXDONE, then apply the end-of-byte rule below.
  - LOW: SCLK=0 for DIV cycles, then go to HIGH.
  - HOLD: SCLK=0, SS=0 for DIV cycles, then go to GAP.
  - GAP: SS=1 for DIV cycles, then go to IDLE. Minimum SS-high time is DIV cycles.
- End-of-byte rule (macro-dependent, see Configuration): either chain straight into the next byte with SS held low, or go to HOLD.
- Accepting a byte into the holding register is independent of the FSM state. If the holding register is loaded and drained on the same edge, the drain wins; TXREADY was 0 on that edge, so no accept occurs.
- MOSI holds its last driven bit until the next load; its reset value is 0.
- Reset values: SCLK=0, MOSI=0, SS=1, TXREADY=1, BUSY=0, TXDONE=0, FSM=IDLE, holding register empty.
- Reset mid-transfer: SS rises and SCLK falls immediately (asynchronously). The partial byte and any held byte are discarded, and no TXDONE is issued.

## Timing
- The receiver samples MOSI on each SCLK rising edge. MOSI is stable at least DIV CLK cycles before and after each rising edge.
- Latency: a byte accepted on edge N drives SS low on edge N+1, provided the FSM is in IDLE.
- Single byte: SS is low for 17*DIV cycles (SETUP + 8 HIGH + 7 LOW + HOLD), followed by DIV cycles of GAP.
- SCLK period: 2*DIV CLK cycles, i.e. SCLK frequency = CLK/(2*DIV). With DIV=1, SCLK = CLK/2.
- TXDONE is high for the one CLK cycle in which SCLK falls after the 8th rising edge.

## Configuration
- SPI_TX_BURST_EN defined:
  - At the end of a byte, if the holding register is full, load the next byte, drive MOSI=bit7, clear the bit counter, and go to LOW with SS kept low.
  - Each chained byte adds 16*DIV cycles to the SS-low window.
  - If the holding register is empty, go to HOLD.
- SPI_TX_BURST_EN undefined:
  - Every byte ends HOLD → GAP → IDLE, so SS always deasserts between bytes.
  - A queued byte starts from IDLE with a fresh SETUP.

## Test plan
- Reset: with RST high, check SS=1, SCLK=0, MOSI=0, TXREADY=1, BUSY=0, TXDONE=0; TXVALID pulses are ignored.
- Single byte, DIV=2, TXDATA=0xA5: exactly 8 SCLK rising edges; MOSI sampled at those edges = 1,0,1,0,0,1,0,1; SS low for 34 CLK then high for at least 2; one TXDONE pulse; the receiver captures 0xA5.
- Back-to-back, DIV=2, 0x3C then 0xC3:
  - with SPI_TX_BURST_EN: 16 rising edges inside a single 66-CLK SS-low window;
  - without it: two 34-CLK SS-low windows separated by at least 2 CLK of SS high;
  - two TXDONE pulses in both cases.
- Backpressure: hold TXVALID high with three bytes (0x01, 0x02, 0x03). TXREADY goes low once the holding register fills; the third byte is accepted only after the second is loaded; the bytes are transmitted in order.
- Reset mid-byte: assert RST after the 3rd SCLK rising edge. SS=1 and SCLK=0 with no CLK edge; no TXDONE. After release, 0x5A transmits correctly.
- DIV=1, TXDATA=0xFF: SCLK toggles every CLK cycle; MOSI stays 1 for the whole byte; SS low for 17 CLK cycles.

Source files
------------

// File: rtl/spi_tx_if.sv
// rtl/spi_tx_if.sv - byte handshake and SPI pin bundle for spi_tx
interface spi_tx_if;
    logic [7:0] txdata;
    logic       txvalid;
    logic       txready;
    logic       sclk;
    logic       mosi;
    logic       ss;
    logic       busy;
    logic       txdone;

    modport master (
        input  txdata, txvalid,
        output txready, sclk, mosi, ss, busy, txdone
    );

    modport slave (
        output txdata, txvalid,
        input  txready, sclk, mosi, ss, busy, txdone
    );
endinterface

// File: rtl/spi_tx.sv
// rtl/spi_tx.sv - mode-0 SPI master transmitter with one-byte holding register
// Optional SPI_TX_BURST_EN: chain a queued byte into the same SS-low window.
module spi_tx #(
    parameter int unsigned DIV = 4
) (
    input  logic      clk,
    input  logic      rst,
    spi_tx_if.master  bus
);
    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;

    localparam logic [7:0] PHASE_LAST = 8'(DIV - 1);

    state_t     state, state_next;
    logic [7:0] hold_q;
    logic       full_q;
    logic [7:0] shift_q;
    logic [2:0] bit_q;
    logic [7:0] phase_q;
    logic       mosi_q;
    logic       done_q;

    logic phase_end;
    logic byte_end;
    logic load_idle;
    logic load_chain;
    logic load;
    logic accept;

    assign phase_end = (phase_q == PHASE_LAST);
    assign byte_end  = (state == HIGH) && phase_end && (bit_q == 3'd7);
    assign load_idle = (state == IDLE) && full_q;
`ifdef SPI_TX_BURST_EN
    assign load_chain = byte_end && full_q;
`else
    assign load_chain = 1'b0;
`endif
    assign load   = load_idle | load_chain;
    assign accept = bus.txvalid & ~full_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (full_q) state_next = SETUP;
            SETUP: if (phase_end) state_next = HIGH;
            HIGH: begin
                if (phase_end) begin
                    if (bit_q != 3'd7) state_next = LOW;
                    else if (load_chain) state_next = LOW;
                    else state_next = HOLD;
                end
            end
            LOW:   if (phase_end) state_next = HIGH;
            HOLD:  if (phase_end) state_next = GAP;
            GAP:   if (phase_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // SS and SCLK decode straight from the state so reset forces them idle without a clock.
    always_comb begin
        bus.sclk    = (state == HIGH);
        bus.ss      = (state == IDLE) || (state == GAP);
        bus.busy    = (state != IDLE);
        bus.txready = ~full_q;
        bus.mosi    = mosi_q;
        bus.txdone  = done_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q  <= 8'h00;
            full_q  <= 1'b0;
            shift_q <= 8'h00;
            bit_q   <= 3'd0;
            phase_q <= 8'h00;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // A drain always beats an accept; they cannot coincide since accept needs ~full.
            if (load) begin
                full_q <= 1'b0;
            end else if (accept) begin
                full_q <= 1'b1;
                hold_q <= bus.txdata;
            end

            phase_q <= (state == IDLE || phase_end) ? 8'h00 : phase_q + 8'h01;
            done_q  <= byte_end;

            if (load) begin
                shift_q <= hold_q;
                mosi_q  <= hold_q[7];
                bit_q   <= 3'd0;
            end else if ((state == HIGH) && phase_end && (bit_q != 3'd7)) begin
                bit_q   <= bit_q + 3'd1;
                mosi_q  <= shift_q[6];
                shift_q <= {shift_q[6:0], 1'b0};
            end
        end
    end
endmodule
